// File: rtl/mem_pkg.sv
// Shared definitions for the block-RAM arbiter: state encoding and default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_I_RD   = 3'd1;
    localparam logic [2:0] ST_I_PUSH = 3'd2;
    localparam logic [2:0] ST_D_RD   = 3'd3;
    localparam logic [2:0] ST_D_PUSH = 3'd4;
    localparam logic [2:0] ST_WR     = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        I_RD   = ST_I_RD,
        I_PUSH = ST_I_PUSH,
        D_RD   = ST_D_RD,
        D_PUSH = ST_D_PUSH,
        WR     = ST_WR
    } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single-port block RAM between fetch and load/store, driving its strobe protocol.
// Latency: read valid 3 cycles after gnt, store done 2 cycles after gnt.
// Backpressure: requests wait (req held) while busy; data wins ties unless fetch has waited MAX_D_STREAK grants.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_d_read,
    output logic              mem_d_write,
    output logic              mem_d_push,
    output logic              mem_i_read,
    output logic              mem_i_push,
    output logic [ADDR_W-1:0] mem_d_addr,
    output logic [ADDR_W-1:0] mem_i_addr,
    inout  wire  [DATA_W-1:0] mem_bus
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    state_t            state;
    logic [SW-1:0]     streak;
    logic [DATA_W-1:0] wdata;
    logic              grant_d;
    logic              grant_i;
    logic              bus_en;

    // Grant selection: only in IDLE; data wins unless the fetch has been starved long enough.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            if (d_req && !(i_req && streak == STREAK_MAX)) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // Grants are masked while reset is asserted so nothing is accepted during reset.
    assign d_gnt = grant_d & rst_n;
    assign i_gnt = grant_i & rst_n;

    // Strobes decode purely from the registered state, so they never glitch on request inputs.
    assign mem_i_read  = (state == I_RD);
    assign mem_i_push  = (state == I_PUSH);
    assign mem_d_read  = (state == D_RD);
    assign mem_d_push  = (state == D_PUSH);
    assign mem_d_write = (state == WR);

    // The arbiter owns the bus only for the write cycle; state resets asynchronously so release is immediate.
    assign bus_en  = (state == WR);
    assign mem_bus = bus_en ? wdata : {DATA_W{1'bz}};

    // Sequencer: operand latch on grant, read/push or write, then valid pulse back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            streak     <= '0;
            wdata      <= '0;
            mem_i_addr <= '0;
            mem_d_addr <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= d_we ? WR : D_RD;
                        mem_d_addr <= d_addr;
                        wdata      <= d_wdata;
                        if (!i_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (grant_i) begin
                        state      <= I_RD;
                        mem_i_addr <= i_addr;
                        streak     <= '0;
                    end else if (!i_req) begin
                        streak <= '0;
                    end
                end
                I_RD: state <= I_PUSH;
                I_PUSH: begin
                    i_rdata <= mem_bus;
                    i_valid <= 1'b1;
                    state   <= IDLE;
                end
                D_RD: state <= D_PUSH;
                D_PUSH: begin
                    d_rdata <= mem_bus;
                    d_valid <= 1'b1;
                    state   <= IDLE;
                end
                WR: begin
                    d_valid <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised bench for mem_arbiter with a behavioural block-RAM on the shared bus.
// Latency: checks read valid at gnt+3 and store completion at gnt+2.
// Backpressure: requests are held until gnt, or dropped early to cancel.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_gnt;
    logic        i_valid;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [15:0] d_rdata;
    logic        mem_d_read;
    logic        mem_d_write;
    logic        mem_d_push;
    logic        mem_i_read;
    logic        mem_i_push;
    logic [15:0] mem_d_addr;
    logic [15:0] mem_i_addr;
    wire  [15:0] mem_bus;

    logic [15:0] mem [256];

    int n_chk = 0;
    int n_err = 0;

    logic [1:0] gseq [10];
    int         gcyc [10];

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_d_read(mem_d_read), .mem_d_write(mem_d_write), .mem_d_push(mem_d_push),
        .mem_i_read(mem_i_read), .mem_i_push(mem_i_push),
        .mem_d_addr(mem_d_addr), .mem_i_addr(mem_i_addr), .mem_bus(mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: drives the bus during push cycles, captures the bus on write cycles.
    assign mem_bus = mem_i_push ? mem[mem_i_addr[7:0]] :
                     mem_d_push ? mem[mem_d_addr[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_d_write) mem[mem_d_addr[7:0]] <= mem_bus;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Records up to n grants (1 = data, 2 = fetch) with their cycle index, giving up after budget cycles.
    task automatic run_grants(input int n, input int budget);
        int got;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            gseq[k] = 2'd0;
            gcyc[k] = -1;
        end
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (d_gnt) begin
                gseq[got] = 2'd1; gcyc[got] = c; got++;
            end else if (i_gnt) begin
                gseq[got] = 2'd2; gcyc[got] = c; got++;
            end
        end
    endtask

    // Protocol monitor: an independent per-requester countdown predicts every strobe, valid and data.
    int          icnt, dcnt;
    logic        dload;
    logic [15:0] iexp, dexp, dwd;
    always @(negedge clk) begin
        if (!rst_n) begin
            icnt = 0; dcnt = 0; dload = 1'b0;
        end else begin
            chk("onehot", 32'($onehot0({mem_i_read, mem_i_push, mem_d_read, mem_d_push, mem_d_write})), 32'd1);
            chk("gnt_excl", 32'(i_gnt & d_gnt), 32'd0);
            chk("i_read", 32'(mem_i_read), 32'(icnt == 3));
            chk("i_push", 32'(mem_i_push), 32'(icnt == 2));
            chk("i_valid", 32'(i_valid), 32'(icnt == 1));
            if (icnt == 1) chk("i_rdata", 32'(i_rdata), 32'(iexp));
            chk("d_read", 32'(mem_d_read), 32'(dload && dcnt == 3));
            chk("d_push", 32'(mem_d_push), 32'(dload && dcnt == 2));
            chk("d_write", 32'(mem_d_write), 32'(!dload && dcnt == 2));
            chk("bus_en", 32'(dut.bus_en), 32'(!dload && dcnt == 2));
            if (!dload && dcnt == 2) chk("wr_bus", 32'(mem_bus), 32'(dwd));
            chk("d_valid", 32'(d_valid), 32'(dcnt == 1));
            if (dload && dcnt == 1) chk("d_rdata", 32'(d_rdata), 32'(dexp));
            if (icnt > 0) icnt--;
            if (dcnt > 0) dcnt--;
            if (i_gnt) begin
                icnt = 3; iexp = mem[i_addr[7:0]];
            end
            if (d_gnt) begin
                dcnt = d_we ? 2 : 3; dload = !d_we; dexp = mem[d_addr[7:0]]; dwd = d_wdata;
            end
        end
    end

    logic [9:0] exp_pat;
    logic [4:0] exp_pat2;
    logic       ig, dg;

    initial begin
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < 256; k++) mem[k] = 16'(k * 16'h0101) ^ 16'hA5A5;
        mem[8'h10] = 16'hB000;

        // Reset state
        #2;
        chk("rst_strobes", 32'({mem_i_read, mem_i_push, mem_d_read, mem_d_push, mem_d_write}), 32'd0);
        chk("rst_gnt_valid", 32'({i_gnt, d_gnt, i_valid, d_valid}), 32'd0);
        chk("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
        chk("rst_addr", 32'({mem_i_addr, mem_d_addr}), 32'd0);
        chk("rst_bus_en", 32'(dut.bus_en), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;

        // Single fetch
        @(posedge clk); #1 i_req = 1'b1; i_addr = 16'h0010;
        @(negedge clk); chk("f_gnt", 32'(i_gnt), 32'd1);
        @(posedge clk); #1 i_req = 1'b0;
        @(negedge clk); chk("f_read", 32'(mem_i_read), 32'd1); chk("f_addr", 32'(mem_i_addr), 32'h0010);
        @(negedge clk); chk("f_push", 32'(mem_i_push), 32'd1);
        @(negedge clk); chk("f_valid", 32'(i_valid), 32'd1); chk("f_rdata", 32'(i_rdata), 32'hB000);

        // Store then load
        @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
        @(negedge clk); chk("st_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk); chk("st_write", 32'(mem_d_write), 32'd1); chk("st_bus", 32'(mem_bus), 32'h1234);
        @(negedge clk); chk("st_valid", 32'(d_valid), 32'd1); chk("st_mem", 32'(mem[8'h40]), 32'h1234);
        @(posedge clk); #1 d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        @(negedge clk); chk("ld_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk); chk("ld_read", 32'(mem_d_read), 32'd1);
        @(negedge clk); chk("ld_push", 32'(mem_d_push), 32'd1);
        @(negedge clk); chk("ld_valid", 32'(d_valid), 32'd1); chk("ld_rdata", 32'(d_rdata), 32'h1234);

        // Contention: both held, expect D D D D I D D D D I
        @(posedge clk); #1 i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 16'h0020; d_addr = 16'h0041;
        run_grants(10, 60);
        exp_pat = 10'b1111011110;
        for (int k = 0; k < 10; k++)
            chk($sformatf("cont_%0d", k), 32'(gseq[k]), exp_pat[9-k] ? 32'd1 : 32'd2);
        @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;
        repeat (4) @(posedge clk);

        // Fetch only: back-to-back grants every 3 cycles
        #1 i_req = 1'b1; i_addr = 16'h0033;
        run_grants(5, 20);
        chk("fo_first", 32'(gcyc[0]), 32'd0);
        for (int k = 1; k < 5; k++)
            chk($sformatf("fo_gap_%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd3);
        // Streak must still be zero: four data grants fit before the fetch
        @(posedge clk); #1 d_req = 1'b1; d_addr = 16'h0042;
        run_grants(5, 30);
        exp_pat2 = 5'b11110;
        for (int k = 0; k < 5; k++)
            chk($sformatf("fo_streak_%0d", k), 32'(gseq[k]), exp_pat2[4-k] ? 32'd1 : 32'd2);
        @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;
        repeat (4) @(posedge clk);

        // Reset in the middle of D_PUSH
        #1 d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        @(negedge clk); chk("rm_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1 d_req = 1'b0;
        @(posedge clk); #1 chk("rm_in_push", 32'(mem_d_push), 32'd1);
        #2 rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1;
        #1;
        chk("rm_strobes", 32'({mem_i_read, mem_i_push, mem_d_read, mem_d_push, mem_d_write}), 32'd0);
        chk("rm_gnt_valid", 32'({i_gnt, d_gnt, i_valid, d_valid}), 32'd0);
        chk("rm_bus_en", 32'(dut.bus_en), 32'd0);
        chk("rm_rdata", 32'(d_rdata), 32'd0);
        chk("rm_addr", 32'(mem_d_addr), 32'd0);
        @(negedge clk); #2 i_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("rm_no_valid", 32'(d_valid), 32'd0);
        end

        // Random traffic with early cancellation; the monitor checks every cycle
        for (int c = 0; c < 400; c++) begin
            @(negedge clk); ig = i_gnt; dg = d_gnt;
            @(posedge clk); #1;
            if (!i_req || ig) begin
                i_req = 1'($urandom_range(0, 1)); i_addr = {8'h00, 8'($urandom)};
            end else if ($urandom_range(0, 7) == 0) begin
                i_req = 1'b0;
            end
            if (!d_req || dg) begin
                d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
                d_addr = {8'h00, 8'($urandom)}; d_wdata = 16'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                d_req = 1'b0;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
